// File: rtl/sticky_flag_sched.sv
// -----------------------------------------------------------------------------
// sticky_flag_sched
//
// Bank of N_FLAGS sticky event flags. Each flag is a registered set-until-
// cleared latch, so the bank powers up to a known state instead of the X that
// a combinational "out = out | in" feedback loop would produce. Pending flags
// (set but not yet reported) are offered one at a time on a valid/ready
// channel. The flag to offer is chosen round-robin, starting from the index
// just after the last accepted report. Flags are cleared by a masked clear
// request, and the request is acknowledged with a one-cycle pulse.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   evt_in     in   N_FLAGS  event strobes, sampled on every clock edge
//   clr_req    in   1        clear request, held together with clr_mask
//                            until clr_ack
//   clr_mask   in   N_FLAGS  flags to clear
//   clr_ack    out  1        one-cycle pulse; the clear is applied on the
//                            edge that ends this cycle
//   flags      out  N_FLAGS  sticky flag state (registered)
//   overflow   out  N_FLAGS  an event arrived while its flag was already set
//                            (sticky)
//   any_flag   out  1        OR of all flags
//   rpt_valid  out  1        report offer valid
//   rpt_ready  in   1        consumer accepts the report
//   rpt_id     out  ID_W     index of the reported flag; stable while
//                            rpt_valid is high
// -----------------------------------------------------------------------------
module sticky_flag_sched #(
    parameter int N_FLAGS = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_FLAGS-1:0] evt_in,
    input  logic               clr_req,
    input  logic [N_FLAGS-1:0] clr_mask,
    output logic               clr_ack,
    output logic [N_FLAGS-1:0] flags,
    output logic [N_FLAGS-1:0] overflow,
    output logic               any_flag,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_FLAGS - 1);

    state_t             state_q,    state_d;
    logic [N_FLAGS-1:0] flags_q,    flags_d;
    logic [N_FLAGS-1:0] overflow_q, overflow_d;
    logic [N_FLAGS-1:0] reported_q, reported_d;
    logic [ID_W-1:0]    ptr_q,      ptr_d;
    logic [ID_W-1:0]    rptId_q,    rptId_d;

    logic [N_FLAGS-1:0] pending;
    logic [N_FLAGS-1:0] clearMask;
    logic               found;
    logic [ID_W-1:0]    pickId;
    int                 idx;

    assign pending = flags_q & ~reported_q;

    // Round-robin search: walk the indices starting at ptr and wrapping at
    // N_FLAGS-1, and stop at the first pending flag. The wrap is done by a
    // subtraction rather than a power-of-two mask, so N_FLAGS need not be a
    // power of two.
    always_comb begin
        found  = 1'b0;
        pickId = '0;
        idx    = 0;
        for (int k = 0; k < N_FLAGS; k++) begin
            if (!found) begin
                idx = int'(ptr_q) + k;
                if (idx >= N_FLAGS) begin
                    idx = idx - N_FLAGS;
                end
                if (pending[idx[ID_W-1:0]]) begin
                    found  = 1'b1;
                    pickId = idx[ID_W-1:0];
                end
            end
        end
    end

    // Next-state logic. In IDLE a clear request beats a pending report. Once
    // an offer is made it is held, and clr_req is ignored, until the consumer
    // accepts it. On the CLEAR edge, an event on a flag that is also being
    // cleared wins: the flag stays set and its reported bit is dropped, so
    // the flag is offered again. The flag's overflow bit is still cleared.
    always_comb begin
        state_d    = state_q;
        rptId_d    = rptId_q;
        ptr_d      = ptr_q;
        reported_d = reported_q;
        clearMask  = '0;

        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (found) begin
                    rptId_d = pickId;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (rpt_ready) begin
                    reported_d[rptId_q] = 1'b1;
                    ptr_d   = (rptId_q == LAST_ID) ? '0 : rptId_q + 1'b1;
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                clearMask = clr_mask;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        reported_d = reported_d & ~clearMask;
        flags_d    = (flags_q & ~clearMask) | evt_in;
        overflow_d = (overflow_q | (evt_in & flags_q)) & ~clearMask;
    end

    // State and flag registers. Every output comes straight from one of
    // these registers, so asserting reset forces all outputs low at once,
    // without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            flags_q    <= '0;
            overflow_q <= '0;
            reported_q <= '0;
            ptr_q      <= '0;
            rptId_q    <= '0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            overflow_q <= overflow_d;
            reported_q <= reported_d;
            ptr_q      <= ptr_d;
            rptId_q    <= rptId_d;
        end
    end

    assign flags     = flags_q;
    assign overflow  = overflow_q;
    assign any_flag  = |flags_q;
    assign rpt_valid = (state_q == OFFER);
    assign clr_ack   = (state_q == CLEAR);
    assign rpt_id    = rptId_q;

endmodule

// File: tb/tb_sticky_flag_sched.sv
// -----------------------------------------------------------------------------
// tb_sticky_flag_sched
//
// Directed testbench for sticky_flag_sched (N_FLAGS=8, ID_W=3). Inputs are
// driven on the falling clock edge, and outputs are checked on the falling
// edge after the rising edge that acts on them. Each expected value is worked
// out by hand and written as a literal next to its check.
// -----------------------------------------------------------------------------
module tb_sticky_flag_sched;

    logic       clk;
    logic       rst_n;
    logic [7:0] evt_in;
    logic       clr_req;
    logic [7:0] clr_mask;
    logic       clr_ack;
    logic [7:0] flags;
    logic [7:0] overflow;
    logic       any_flag;
    logic       rpt_valid;
    logic       rpt_ready;
    logic [2:0] rpt_id;

    int testsRun;
    int testsFailed;

    sticky_flag_sched #(
        .N_FLAGS(8),
        .ID_W   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt_in   (evt_in),
        .clr_req  (clr_req),
        .clr_mask (clr_mask),
        .clr_ack  (clr_ack),
        .flags    (flags),
        .overflow (overflow),
        .any_flag (any_flag),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_id   (rpt_id)
    );

    // 10 ns clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison. Arguments are 4-state, so an X on the DUT side fails
    // the strict equality test.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] evt, input logic req,
                                 input logic [7:0] mask, input logic ready);
        evt_in    = evt;
        clr_req   = req;
        clr_mask  = mask;
        rpt_ready = ready;
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks every output against its reset value.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".flags"},     32'(flags),     32'h0);
        checkOutput({tag, ".overflow"},  32'(overflow),  32'h0);
        checkOutput({tag, ".any_flag"},  32'(any_flag),  32'h0);
        checkOutput({tag, ".rpt_valid"}, 32'(rpt_valid), 32'h0);
        checkOutput({tag, ".clr_ack"},   32'(clr_ack),   32'h0);
        checkOutput({tag, ".rpt_id"},    32'(rpt_id),    32'h0);
    endtask

    // Pulses reset between rising edges, so the pointer starts again from 0.
    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        nextCycle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);

        // ---- Test 1: reset values, then 10 idle cycles ----
        nextCycle(3);
        checkAllZero("rst");
        rst_n = 1'b1;
        nextCycle(10);
        checkAllZero("idle10");

        // ---- Test 2: single event on bit 2 ----
        applyStimulus(8'h04, 1'b0, 8'h00, 1'b1);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("t2.flags",    32'(flags),     32'h04);
        checkOutput("t2.anyFlag",  32'(any_flag),  32'h1);
        checkOutput("t2.validEarly", 32'(rpt_valid), 32'h0);
        nextCycle(1);
        checkOutput("t2.valid",    32'(rpt_valid), 32'h1);
        checkOutput("t2.id",       32'(rpt_id),    32'h2);
        for (int i = 0; i < 4; i++) begin
            nextCycle(1);
            checkOutput("t2.noReReport", 32'(rpt_valid), 32'h0);
            checkOutput("t2.flagsHold",  32'(flags),     32'h04);
        end

        // ---- Test 3: two events, round-robin order and pointer wrap ----
        pulseReset();
        applyStimulus(8'h81, 1'b0, 8'h00, 1'b1);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("t3.flags", 32'(flags), 32'h81);
        nextCycle(1);
        checkOutput("t3.valid0", 32'(rpt_valid), 32'h1);
        checkOutput("t3.id0",    32'(rpt_id),    32'h0);
        nextCycle(1);
        checkOutput("t3.gap",    32'(rpt_valid), 32'h0);
        nextCycle(1);
        checkOutput("t3.valid7", 32'(rpt_valid), 32'h1);
        checkOutput("t3.id7",    32'(rpt_id),    32'h7);
        nextCycle(1);
        applyStimulus(8'h00, 1'b1, 8'h81, 1'b1);
        nextCycle(1);
        checkOutput("t3.ack", 32'(clr_ack), 32'h1);
        applyStimulus(8'h00, 1'b0, 8'h81, 1'b1);
        nextCycle(1);
        applyStimulus(8'h81, 1'b0, 8'h00, 1'b1);
        checkOutput("t3.cleared", 32'(flags),   32'h00);
        checkOutput("t3.ackDrop", 32'(clr_ack), 32'h0);
        // Both bits pending again: after wrapping the pointer is 0, so id 0
        // is offered before id 7.
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        nextCycle(1);
        checkOutput("t3.wrapValid", 32'(rpt_valid), 32'h1);
        checkOutput("t3.wrapId",    32'(rpt_id),    32'h0);

        // ---- Test 4: event on the clearing edge wins ----
        pulseReset();
        applyStimulus(8'h04, 1'b0, 8'h00, 1'b1);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        nextCycle(1);
        checkOutput("t4.id", 32'(rpt_id), 32'h2);
        nextCycle(1);
        applyStimulus(8'h00, 1'b1, 8'h04, 1'b1);
        nextCycle(1);
        checkOutput("t4.ack", 32'(clr_ack), 32'h1);
        applyStimulus(8'h04, 1'b0, 8'h04, 1'b1);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("t4.flags",    32'(flags),    32'h04);
        checkOutput("t4.overflow", 32'(overflow), 32'h00);
        checkOutput("t4.ackDrop",  32'(clr_ack),  32'h0);
        nextCycle(1);
        checkOutput("t4.reValid", 32'(rpt_valid), 32'h1);
        checkOutput("t4.reId",    32'(rpt_id),    32'h2);
        nextCycle(1);

        // ---- Test 5: stalled offer holds while a clear waits ----
        applyStimulus(8'h10, 1'b0, 8'h00, 1'b0);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t5.flags", 32'(flags), 32'h14);
        nextCycle(1);
        applyStimulus(8'h00, 1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5.holdValid", 32'(rpt_valid), 32'h1);
            checkOutput("t5.holdId",    32'(rpt_id),    32'h4);
            checkOutput("t5.noAck",     32'(clr_ack),   32'h0);
            nextCycle(1);
        end
        applyStimulus(8'h00, 1'b1, 8'h10, 1'b1);
        nextCycle(1);
        checkOutput("t5.accepted", 32'(rpt_valid), 32'h0);
        checkOutput("t5.ackWait",  32'(clr_ack),   32'h0);
        nextCycle(1);
        checkOutput("t5.ack", 32'(clr_ack), 32'h1);
        applyStimulus(8'h00, 1'b0, 8'h10, 1'b1);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t5.flags2", 32'(flags),   32'h04);
        checkOutput("t5.ackEnd", 32'(clr_ack), 32'h0);

        // ---- Test 6: overflow, its clear, and async reset mid-offer ----
        applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("t6.ovfFirst", 32'(overflow), 32'h00);
        nextCycle(1);
        checkOutput("t6.id3", 32'(rpt_id), 32'h3);
        applyStimulus(8'h08, 1'b0, 8'h00, 1'b0);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        checkOutput("t6.ovf",      32'(overflow), 32'h08);
        checkOutput("t6.flags",    32'(flags),    32'h0C);
        nextCycle(1);
        applyStimulus(8'h00, 1'b1, 8'h08, 1'b0);
        nextCycle(1);
        checkOutput("t6.ack", 32'(clr_ack), 32'h1);
        applyStimulus(8'h00, 1'b0, 8'h08, 1'b0);
        nextCycle(1);
        applyStimulus(8'h20, 1'b0, 8'h00, 1'b0);
        checkOutput("t6.ovfCleared",   32'(overflow), 32'h00);
        checkOutput("t6.flagsCleared", 32'(flags),    32'h04);
        nextCycle(1);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        nextCycle(1);
        checkOutput("t6.valid5", 32'(rpt_valid), 32'h1);
        checkOutput("t6.id5",    32'(rpt_id),    32'h5);
        // Reset asserted between clock edges must clear outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("t6.asyncRst");
        nextCycle(1);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
